// File: rtl/minterm_scanner.sv
// Sequential truth-table reader: steps sel_out through every input combination of a
// small combinational function, samples f_in after a settle delay, and reports the minterm mask and count.
module minterm_scanner #(
  parameter int N_INPUTS = 3,
  parameter int SETTLE   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      f_in,
  output logic [N_INPUTS-1:0]       sel_out,
  output logic                      busy,
  output logic                      done,
  output logic [2**N_INPUTS-1:0]    minterm_mask,
  output logic [N_INPUTS:0]         minterm_count
);

  localparam int N_COMB = 2**N_INPUTS;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0]          SETTLE_VAL = 4'(SETTLE);
  localparam logic [N_INPUTS-1:0] SEL_LAST   = N_INPUTS'(N_COMB - 1);
  // With no settle time the DRIVE state is skipped entirely.
  localparam logic [1:0]          ST_ENTRY   = (SETTLE == 0) ? ST_SAMPLE : ST_DRIVE;

  logic [1:0]          state_reg, state_next;
  logic [3:0]          settle_reg, settle_next;
  logic [N_INPUTS-1:0] sel_reg, sel_next;
  logic [N_COMB-1:0]   mask_reg, mask_next;
  logic [N_INPUTS:0]   count_reg, count_next;

  logic accept;
  logic sampling;

  assign accept   = (state_reg == ST_IDLE) && start;
  assign sampling = (state_reg == ST_SAMPLE);

  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg;
    sel_next    = sel_reg;
    count_next  = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next  = ST_ENTRY;
          settle_next = SETTLE_VAL;
          sel_next    = '0;
          count_next  = '0;
        end
      end
      ST_DRIVE: begin
        settle_next = settle_reg - 4'd1;
        if (settle_reg <= 4'd1) begin
          state_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (f_in) begin
          count_next = count_reg + 1'b1;
        end
        if (sel_reg == SEL_LAST) begin
          state_next = ST_DONE;
        end else begin
          sel_next    = sel_reg + 1'b1;
          settle_next = SETTLE_VAL;
          state_next  = ST_ENTRY;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Each mask bit is cleared on acceptance and captures f_in only while its own index is driven.
  generate
    for (genvar gi = 0; gi < N_COMB; gi++) begin : g_mask
      assign mask_next[gi] = accept ? 1'b0 :
                             (sampling && (sel_reg == N_INPUTS'(gi))) ? f_in :
                             mask_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      settle_reg <= '0;
      sel_reg    <= '0;
      mask_reg   <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      settle_reg <= settle_next;
      sel_reg    <= sel_next;
      mask_reg   <= mask_next;
      count_reg  <= count_next;
    end
  end

  assign sel_out       = sel_reg;
  assign busy          = (state_reg == ST_DRIVE) || (state_reg == ST_SAMPLE);
  assign done          = (state_reg == ST_DONE);
  assign minterm_mask  = mask_reg;
  assign minterm_count = count_reg;

endmodule

// File: tb/tb_minterm_scanner.sv
// Self-checking bench for minterm_scanner: three instances (default, SETTLE=0, N_INPUTS=2/SETTLE=2)
// with a scoreboard of expected scan results popped at each done pulse.
module tb_minterm_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start0, start1, start2;
  logic [1:0] mode0;
  logic f_in0, f_in1, f_in2;
  logic [2:0] sel0, sel1;
  logic [1:0] sel2;
  logic busy0, busy1, busy2, done0, done1, done2;
  logic [7:0] mask0, mask1;
  logic [3:0] mask2;
  logic [3:0] cnt0, cnt1;
  logic [2:0] cnt2;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    int          inst;
    logic [63:0] mask;
    int          count;
    int          lat;
  } exp_t;
  exp_t sb[$];

  // Function under test for instance 0: A = sel0[2], B = sel0[1], C = sel0[0].
  always_comb begin
    f_in0 = 1'b0;
    case (mode0)
      2'd0: f_in0 = (sel0 == 3'd5);
      2'd1: f_in0 = (sel0[2] & sel0[1]) | (sel0[2] & sel0[0]) | (sel0[1] & sel0[0]);
      2'd2: f_in0 = 1'b1;
      default: f_in0 = 1'b0;
    endcase
  end
  assign f_in2 = sel2[1] ^ sel2[0];

  minterm_scanner #(.N_INPUTS(3), .SETTLE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .f_in(f_in0), .sel_out(sel0),
    .busy(busy0), .done(done0), .minterm_mask(mask0), .minterm_count(cnt0));
  minterm_scanner #(.N_INPUTS(3), .SETTLE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .f_in(f_in1), .sel_out(sel1),
    .busy(busy1), .done(done1), .minterm_mask(mask1), .minterm_count(cnt1));
  minterm_scanner #(.N_INPUTS(2), .SETTLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .f_in(f_in2), .sel_out(sel2),
    .busy(busy2), .done(done2), .minterm_mask(mask2), .minterm_count(cnt2));

  function automatic int settle_of(input int inst);
    case (inst)
      0: return 1;
      1: return 0;
      default: return 2;
    endcase
  endfunction

  function automatic int sel_of(input int inst);
    case (inst)
      0: return int'(sel0);
      1: return int'(sel1);
      default: return int'(sel2);
    endcase
  endfunction

  function automatic logic busy_of(input int inst);
    case (inst)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic done_of(input int inst);
    case (inst)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic [63:0] mask_of(input int inst);
    case (inst)
      0: return {56'd0, mask0};
      1: return {56'd0, mask1};
      default: return {60'd0, mask2};
    endcase
  endfunction

  function automatic int cnt_of(input int inst);
    case (inst)
      0: return int'(cnt0);
      1: return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  // Runs one scan and gathers observations; j counts falling edges after the accept edge.
  task automatic run_scan(input int inst, output int cyc, output int busy_cyc, output int sel_bad,
                          output logic [63:0] first_mask, output int first_cnt, output bit timeout);
    int s;
    s = settle_of(inst);
    cyc = 0; busy_cyc = 0; sel_bad = 0; timeout = 0;
    first_mask = '1; first_cnt = -1;
    @(negedge clk);
    set_start(inst, 1'b1);
    forever begin
      @(negedge clk);
      set_start(inst, 1'b0);
      if (done_of(inst)) break;
      if (cyc == 0) begin
        first_mask = mask_of(inst);
        first_cnt  = cnt_of(inst);
      end
      if (busy_of(inst)) busy_cyc++;
      if (sel_of(inst) != cyc / (s + 1)) sel_bad++;
      cyc++;
      if (cyc > 300) begin
        timeout = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start0 = 0; start1 = 0; start2 = 0; mode0 = 0; f_in1 = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_compared++;
      if (sel_of(i) !== 0 || busy_of(i) !== 1'b0 || done_of(i) !== 1'b0 ||
          mask_of(i) !== 64'd0 || cnt_of(i) !== 0) begin
        n_mismatched++;
        $display("FAIL reset_state inst%0d: sel=%0d busy=%b done=%b mask=%h cnt=%0d, required all zero",
                 i, sel_of(i), busy_of(i), done_of(i), mask_of(i), cnt_of(i));
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_minterm();
    int cyc, bc, sb_bad, c0;
    logic [63:0] m0;
    bit to;
    exp_t e;
    mode0 = 2'd0;
    sb.push_back('{0, 64'h20, 1, 16});
    run_scan(0, cyc, bc, sb_bad, m0, c0, to);
    e = sb.pop_front();
    $display("scan inst%0d sel==5: latency=%0d mask=%h count=%0d", e.inst, cyc, mask_of(0), cnt_of(0));
    n_compared++;
    if (to !== 1'b0) begin n_mismatched++; $display("FAIL single_timeout: no done within bound"); end
    n_compared++;
    if (cyc !== e.lat) begin n_mismatched++; $display("FAIL single_latency: got %0d, required %0d", cyc, e.lat); end
    n_compared++;
    if (bc !== 16) begin n_mismatched++; $display("FAIL single_busy_cycles: got %0d, required 16", bc); end
    n_compared++;
    if (sb_bad !== 0) begin n_mismatched++; $display("FAIL single_sel_sequence: %0d bad cycles, required 0", sb_bad); end
    n_compared++;
    if (mask_of(0) !== e.mask) begin n_mismatched++; $display("FAIL single_mask: got %h, required %h", mask_of(0), e.mask); end
    n_compared++;
    if (cnt_of(0) !== e.count) begin n_mismatched++; $display("FAIL single_count: got %0d, required %0d", cnt_of(0), e.count); end
    n_compared++;
    if (busy0 !== 1'b0 || sel0 !== 3'd7) begin
      n_mismatched++; $display("FAIL single_done_cycle: busy=%b sel=%0d, required busy=0 sel=7", busy0, sel0);
    end
    @(negedge clk);
    n_compared++;
    if (done0 !== 1'b0 || mask0 !== 8'h20) begin
      n_mismatched++; $display("FAIL single_after_done: done=%b mask=%h, required done=0 mask=20", done0, mask0);
    end
  endtask

  task automatic test_majority();
    int cyc, bc, sb_bad, c0;
    logic [63:0] m0;
    bit to;
    exp_t e;
    mode0 = 2'd1;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{0, 64'hE8, 4, 16});
      run_scan(0, cyc, bc, sb_bad, m0, c0, to);
      e = sb.pop_front();
      $display("scan inst%0d majority pass %0d: latency=%0d mask=%h count=%0d", e.inst, k, cyc, mask_of(0), cnt_of(0));
      n_compared++;
      if (to !== 1'b0 || cyc !== e.lat) begin
        n_mismatched++; $display("FAIL majority_latency pass%0d: got %0d timeout=%b, required %0d", k, cyc, to, e.lat);
      end
      n_compared++;
      if (mask_of(0) !== e.mask || cnt_of(0) !== e.count) begin
        n_mismatched++; $display("FAIL majority_result pass%0d: mask=%h count=%0d, required %h/%0d",
                                 k, mask_of(0), cnt_of(0), e.mask, e.count);
      end
      if (k == 1) begin
        n_compared++;
        if (m0 !== 64'd0 || c0 !== 0) begin
          n_mismatched++; $display("FAIL majority_clear_on_start: mask=%h count=%0d, required 0/0", m0, c0);
        end
      end
    end
  endtask

  task automatic test_settle0();
    int cyc, bc, sb_bad, c0;
    logic [63:0] m0;
    bit to;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      f_in1 = (k == 0);
      sb.push_back('{1, (k == 0) ? 64'hFF : 64'h0, (k == 0) ? 8 : 0, 8});
      run_scan(1, cyc, bc, sb_bad, m0, c0, to);
      e = sb.pop_front();
      $display("scan inst%0d const f_in=%b: latency=%0d mask=%h count=%0d", e.inst, f_in1, cyc, mask_of(1), cnt_of(1));
      n_compared++;
      if (to !== 1'b0 || cyc !== e.lat || bc !== 8) begin
        n_mismatched++; $display("FAIL settle0_latency f=%b: got %0d busy=%0d timeout=%b, required %0d/8", f_in1, cyc, bc, to, e.lat);
      end
      n_compared++;
      if (mask_of(1) !== e.mask || cnt_of(1) !== e.count || sb_bad !== 0) begin
        n_mismatched++; $display("FAIL settle0_result f=%b: mask=%h count=%0d selbad=%0d, required %h/%0d/0",
                                 f_in1, mask_of(1), cnt_of(1), sb_bad, e.mask, e.count);
      end
    end
  endtask

  task automatic test_start_held();
    int n_done, done_at[$], idle_at[$];
    exp_t e;
    mode0 = 2'd0;
    n_done = 0;
    sb.push_back('{0, 64'h20, 1, 16});
    sb.push_back('{0, 64'h20, 1, 34});
    @(negedge clk);
    start0 = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done0) begin
        n_done++;
        done_at.push_back(j);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          $display("scan inst%0d start held: done at %0d mask=%h count=%0d", e.inst, j, mask0, cnt0);
          n_compared++;
          if (j !== e.lat || {56'd0, mask0} !== e.mask || int'(cnt0) !== e.count) begin
            n_mismatched++; $display("FAIL held_scan_result: at=%0d mask=%h count=%0d, required %0d/%h/%0d",
                                     j, mask0, cnt0, e.lat, e.mask, e.count);
          end
        end
      end else if (!busy0) begin
        idle_at.push_back(j);
      end
    end
    start0 = 1'b0;
    n_compared++;
    if (n_done !== 2) begin n_mismatched++; $display("FAIL held_done_count: got %0d, required 2", n_done); end
    n_compared++;
    if (idle_at.size() !== 2 || (idle_at.size() == 2 && (idle_at[0] !== 17 || idle_at[1] !== 35))) begin
      n_mismatched++; $display("FAIL held_idle_gaps: %0d idle cycles, required exactly at 17 and 35", idle_at.size());
    end
    sb.delete();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_scan();
    int cyc, bc, sb_bad, c0, n_done;
    logic [63:0] m0;
    bit to;
    exp_t e;
    mode0 = 2'd2;
    @(negedge clk);
    start0 = 1'b1;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    n_compared++;
    if (mask0 !== 8'h07 || cnt0 !== 4'd3 || sel0 !== 3'd3) begin
      n_mismatched++; $display("FAIL midscan_partial: mask=%h count=%0d sel=%0d, required 07/3/3", mask0, cnt0, sel0);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_compared++;
    if (sel0 !== 3'd0 || busy0 !== 1'b0 || done0 !== 1'b0 || mask0 !== 8'h00 || cnt0 !== 4'd0) begin
      n_mismatched++; $display("FAIL async_reset: sel=%0d busy=%b done=%b mask=%h cnt=%0d, required all zero",
                               sel0, busy0, done0, mask0, cnt0);
    end
    n_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done0) n_done++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done0) n_done++;
    end
    n_compared++;
    if (n_done !== 0) begin n_mismatched++; $display("FAIL reset_no_done: got %0d pulses, required 0", n_done); end
    mode0 = 2'd1;
    sb.push_back('{0, 64'hE8, 4, 16});
    run_scan(0, cyc, bc, sb_bad, m0, c0, to);
    e = sb.pop_front();
    $display("scan inst%0d after reset: latency=%0d mask=%h count=%0d", e.inst, cyc, mask_of(0), cnt_of(0));
    n_compared++;
    if (to !== 1'b0 || cyc !== e.lat || mask_of(0) !== e.mask || cnt_of(0) !== e.count || sb_bad !== 0) begin
      n_mismatched++; $display("FAIL post_reset_scan: lat=%0d mask=%h count=%0d, required %0d/%h/%0d",
                               cyc, mask_of(0), cnt_of(0), e.lat, e.mask, e.count);
    end
  endtask

  task automatic test_n2_settle2();
    int cyc, bc, sb_bad, c0;
    logic [63:0] m0;
    bit to;
    exp_t e;
    sb.push_back('{2, 64'h6, 2, 12});
    run_scan(2, cyc, bc, sb_bad, m0, c0, to);
    e = sb.pop_front();
    $display("scan inst%0d xor: latency=%0d mask=%h count=%0d", e.inst, cyc, mask_of(2), cnt_of(2));
    n_compared++;
    if (to !== 1'b0 || cyc !== e.lat || bc !== 12) begin
      n_mismatched++; $display("FAIL n2_latency: got %0d busy=%0d timeout=%b, required %0d/12", cyc, bc, to, e.lat);
    end
    n_compared++;
    if (mask_of(2) !== e.mask || cnt_of(2) !== e.count || sb_bad !== 0 || sel2 !== 2'd3) begin
      n_mismatched++; $display("FAIL n2_result: mask=%h count=%0d selbad=%0d sel=%0d, required %h/%0d/0/3",
                               mask_of(2), cnt_of(2), sb_bad, sel2, e.mask, e.count);
    end
  endtask

  initial begin
    test_reset();
    test_single_minterm();
    test_majority();
    test_settle0();
    test_start_held();
    test_reset_mid_scan();
    test_n2_settle2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/minterm_scanner.md
Name: minterm_scanner

Overview:
- Sequential truth-table reader for a combinational N-input boolean function block (e.g. a mux-built minterm function).
- Drives every input combination onto the function under test and samples its output, settling after each.
- Reports the resulting minterm mask and minterm count.
- Used for bring-up and self-check of small logic functions: it recovers the minterm list from an implementation.

Parameters:
- N_INPUTS, 3, number of function inputs; combinations scanned = 2^N_INPUTS; legal range 1..6.
- SETTLE, 1, DRIVE cycles held before each sample; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  scan request; sampled only in IDLE.
- f_in  input  1  output of the function under test; sampled in SAMPLE state.
- sel_out  output  N_INPUTS  input combination driven to the function; MSB = first input (A), LSB = last input (C); value = minterm index.
- busy  output  1  high from the cycle after start acceptance until the done cycle, exclusive.
- done  output  1  one-cycle pulse at scan completion.
- minterm_mask  output  2^N_INPUTS  bit i = f_in captured while sel_out == i.
- minterm_count  output  N_INPUTS+1  number of set bits in minterm_mask.

Behaviour:
- Reset (async, rst_n low): state IDLE; sel_out=0, busy=0, done=0, minterm_mask=0, minterm_count=0; settle counter=0.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - On start=1 at a clock edge: go to DRIVE, or to SAMPLE if SETTLE=0.
  - At the same edge: sel_out=0, minterm_mask=0, minterm_count=0, settle counter=SETTLE.
  - start=0: stay in IDLE; outputs hold their last results.
- DRIVE: settle counter decrements each cycle; after exactly SETTLE cycles in DRIVE, go to SAMPLE. sel_out is stable throughout.
- SAMPLE: one cycle. At its closing edge:
  - minterm_mask[sel_out] <= f_in.
  - minterm_count increments if f_in=1.
  - If sel_out == 2^N_INPUTS-1: go to DONE, sel_out holds.
  - Otherwise: sel_out+1, settle counter reloaded, go to DRIVE (or SAMPLE if SETTLE=0).
- DONE: one cycle with done=1, busy=0; then IDLE. start is ignored in the DONE cycle.
- busy=1 in every DRIVE and SAMPLE cycle.
- Latency, start-accept edge to done high: 2^N_INPUTS*(SETTLE+1) cycles. Defaults: 16 cycles.
- start while busy or in DONE: ignored; no restart, no effect on results.
- minterm_mask and minterm_count update progressively during the scan. They are valid and stable from the done cycle until the next accepted start.
- Reset mid-scan: immediate return to the reset values; partial results are discarded; no done pulse.
- f_in is assumed to be a registered or combinational function of sel_out only. The block adds no synchronizer.
- sel_out wraps only via a new scan; it never exceeds 2^N_INPUTS-1.

Test Plan:
- Defaults, f_in = (sel_out==5), start pulse -> sel_out steps 0..7 with each value held 2 cycles; done high 16 cycles after the accept edge; mask=8'h20, count=1; busy high exactly 16 cycles.
- Defaults, f_in = majority(A,B,C) (minterms 3,5,6,7) -> mask=8'hE8, count=4; a second identical scan gives the same results and clears the mask at its start.
- SETTLE=0, f_in=1 constant -> done 8 cycles after accept, mask=8'hFF, count=8; f_in=0 constant -> mask=0, count=0, done still pulses.
- Defaults, start held high continuously -> a new scan is accepted only on the cycle after DONE; exactly one done pulse per scan; no start accepted while busy.
- Defaults, rst_n low asynchronously during cycle 7 of a scan (mid-edge timing) -> all outputs 0 immediately with no clock needed; no done pulse; a subsequent start runs a full clean scan.
- N_INPUTS=2, SETTLE=2, f_in = XOR of the sel_out bits -> mask=4'b0110, count=2, done 12 cycles after accept.
